// File: rtl/zxuno_regbus_ctrl.sv
// ZX-UNO register bus controller: decodes CPU I/O cycles on the address/data ports,
// holds the selected register number and returns peripheral read data to the CPU.
module zxuno_regbus_ctrl #(
    parameter int          NSLAVES   = 8,
    parameter logic [15:0] ADDR_PORT = 16'hFC3B,
    parameter logic [15:0] DATA_PORT = 16'hFD3B,
    parameter logic [7:0]  ADDR_RST  = 8'h00
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [15:0]            cpu_a,
    input  logic                   cpu_iorq_n,
    input  logic                   cpu_rd_n,
    input  logic                   cpu_wr_n,
    input  logic [7:0]             cpu_din,
    output logic [7:0]             cpu_dout,
    output logic                   cpu_oe_n,
    output logic [7:0]             zxuno_addr,
    output logic                   zxuno_regrd,
    output logic                   zxuno_regwr,
    output logic [7:0]             zxuno_wdata,
    output logic                   regaddr_changed,
    input  logic [8*NSLAVES-1:0]   slv_dout,
    input  logic [NSLAVES-1:0]     slv_oe_n,
    output logic                   conflict
);

    typedef enum logic [1:0] {
        ST_HOLD   = 2'd0,
        ST_IDLE   = 2'd1,
        ST_RDADDR = 2'd2,
        ST_RDDATA = 2'd3
    } state_t;

    // Lowest-index responding slave wins; nobody responding reads as 8'hFF.
    function automatic logic [7:0] mux_read(input logic [8*NSLAVES-1:0] dout,
                                            input logic [NSLAVES-1:0] oe_n);
        logic [7:0] result;
        logic       found;
        result = 8'hFF;
        found  = 1'b0;
        for (int k = 0; k < NSLAVES; k++) begin
            if (!oe_n[k] && !found) begin
                result = dout[8*k +: 8];
                found  = 1'b1;
            end
        end
        return result;
    endfunction

    function automatic logic multi_drive(input logic [NSLAVES-1:0] oe_n);
        logic found;
        logic multi;
        found = 1'b0;
        multi = 1'b0;
        for (int k = 0; k < NSLAVES; k++) begin
            multi = multi | (found & ~oe_n[k]);
            found = found | ~oe_n[k];
        end
        return multi;
    endfunction

    logic        iorq_meta_r, rd_meta_r, wr_meta_r;
    logic        iorq_sync_r, rd_sync_r, wr_sync_r;
    logic [15:0] a_r;
    logic [7:0]  din_r;
    logic        rd_s, wr_s, acc_s;
    logic [7:0]  mux_dout_s;
    logic        multi_s;
    state_t      state_r;

    // Strobe synchroniser; left out of reset so a strobe held through reset is still seen.
    always_ff @(posedge clk) begin
        iorq_meta_r <= cpu_iorq_n;
        rd_meta_r   <= cpu_rd_n;
        wr_meta_r   <= cpu_wr_n;
        iorq_sync_r <= iorq_meta_r;
        rd_sync_r   <= rd_meta_r;
        wr_sync_r   <= wr_meta_r;
        a_r         <= cpu_a;
        din_r       <= cpu_din;
    end

    assign rd_s       = ~iorq_sync_r & ~rd_sync_r;
    assign wr_s       = ~iorq_sync_r & ~wr_sync_r;
    assign acc_s      = rd_s | wr_s;
    assign mux_dout_s = mux_read(slv_dout, slv_oe_n);
    assign multi_s    = multi_drive(slv_oe_n);

    // Access sequencer with registered bus outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r         <= ST_HOLD;
            zxuno_addr      <= ADDR_RST;
            zxuno_regrd     <= 1'b0;
            zxuno_regwr     <= 1'b0;
            zxuno_wdata     <= 8'h00;
            regaddr_changed <= 1'b0;
            conflict        <= 1'b0;
            cpu_oe_n        <= 1'b1;
            cpu_dout        <= 8'hFF;
        end else begin
            zxuno_regwr     <= 1'b0;
            regaddr_changed <= 1'b0;
            case (state_r)
                ST_HOLD: begin
                    if (!acc_s) begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_IDLE: begin
                    // Write wins over a simultaneous read.
                    if (wr_s) begin
                        if (a_r == ADDR_PORT) begin
                            zxuno_addr      <= din_r;
                            regaddr_changed <= 1'b1;
                            state_r         <= ST_HOLD;
                        end else if (a_r == DATA_PORT) begin
                            zxuno_wdata <= din_r;
                            zxuno_regwr <= 1'b1;
                            state_r     <= ST_HOLD;
                        end
                    end else if (rd_s) begin
                        if (a_r == ADDR_PORT) begin
                            cpu_oe_n <= 1'b0;
                            cpu_dout <= zxuno_addr;
                            state_r  <= ST_RDADDR;
                        end else if (a_r == DATA_PORT) begin
                            zxuno_regrd <= 1'b1;
                            cpu_oe_n    <= 1'b0;
                            cpu_dout    <= mux_dout_s;
                            state_r     <= ST_RDDATA;
                        end
                    end
                end
                ST_RDADDR: begin
                    if (rd_s) begin
                        cpu_oe_n <= 1'b0;
                        cpu_dout <= zxuno_addr;
                    end else begin
                        cpu_oe_n <= 1'b1;
                        cpu_dout <= 8'hFF;
                        state_r  <= ST_IDLE;
                    end
                end
                ST_RDDATA: begin
                    conflict <= conflict | multi_s;
                    if (rd_s) begin
                        zxuno_regrd <= 1'b1;
                        cpu_oe_n    <= 1'b0;
                        cpu_dout    <= mux_dout_s;
                    end else begin
                        zxuno_regrd <= 1'b0;
                        cpu_oe_n    <= 1'b1;
                        cpu_dout    <= 8'hFF;
                        state_r     <= ST_IDLE;
                    end
                end
                default: begin
                    state_r <= ST_HOLD;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_zxuno_regbus_ctrl.sv
// Directed self-checking bench for zxuno_regbus_ctrl: port writes/reads, read mux
// priority and conflict flag, strobe hold behaviour and reset mid-read.
module tb_zxuno_regbus_ctrl;

    logic        clk;
    logic        rst_n;
    logic [15:0] cpu_a;
    logic        cpu_iorq_n, cpu_rd_n, cpu_wr_n;
    logic [7:0]  cpu_din;
    logic [7:0]  cpu_dout;
    logic        cpu_oe_n;
    logic [7:0]  zxuno_addr;
    logic        zxuno_regrd, zxuno_regwr;
    logic [7:0]  zxuno_wdata;
    logic        regaddr_changed;
    logic [63:0] slv_dout;
    logic [7:0]  slv_oe_n;
    logic        conflict;

    int checks = 0;
    int errors = 0;
    int pulses;
    int first;

    zxuno_regbus_ctrl dut (
        .clk(clk), .rst_n(rst_n), .cpu_a(cpu_a), .cpu_iorq_n(cpu_iorq_n),
        .cpu_rd_n(cpu_rd_n), .cpu_wr_n(cpu_wr_n), .cpu_din(cpu_din),
        .cpu_dout(cpu_dout), .cpu_oe_n(cpu_oe_n), .zxuno_addr(zxuno_addr),
        .zxuno_regrd(zxuno_regrd), .zxuno_regwr(zxuno_regwr),
        .zxuno_wdata(zxuno_wdata), .regaddr_changed(regaddr_changed),
        .slv_dout(slv_dout), .slv_oe_n(slv_oe_n), .conflict(conflict)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic strobe(input logic [15:0] a, input logic [7:0] d, input logic rd, input logic wr);
        cpu_a      = a;
        cpu_din    = d;
        cpu_iorq_n = 1'b0;
        cpu_rd_n   = ~rd;
        cpu_wr_n   = ~wr;
    endtask

    task automatic release_bus();
        cpu_iorq_n = 1'b1;
        cpu_rd_n   = 1'b1;
        cpu_wr_n   = 1'b1;
    endtask

    initial begin
        rst_n    = 1'b0;
        cpu_a    = 16'h0000;
        cpu_din  = 8'h00;
        release_bus();
        slv_dout = 64'h0;
        slv_oe_n = 8'hFF;
        tick(4);
        chk("rst_addr", zxuno_addr, 8'h00);
        chk("rst_regrd", zxuno_regrd, 1'b0);
        chk("rst_regwr", zxuno_regwr, 1'b0);
        chk("rst_changed", regaddr_changed, 1'b0);
        chk("rst_conflict", conflict, 1'b0);
        chk("rst_oe_n", cpu_oe_n, 1'b1);
        chk("rst_dout", cpu_dout, 8'hFF);
        chk("rst_wdata", zxuno_wdata, 8'h00);
        rst_n = 1'b1;
        tick(3);

        // Address port write FF: pulse exactly 3 clk after the strobe, 1 clk wide
        strobe(16'hFC3B, 8'hFF, 1'b0, 1'b1);
        tick(2);
        chk("aw_early", regaddr_changed, 1'b0);
        tick(1);
        chk("aw_pulse", regaddr_changed, 1'b1);
        chk("aw_addr", zxuno_addr, 8'hFF);
        tick(1);
        chk("aw_pulse_end", regaddr_changed, 1'b0);
        release_bus();
        tick(4);

        // Data port write 5A held 20 clk: single regwr pulse
        strobe(16'hFD3B, 8'h5A, 1'b0, 1'b1);
        pulses = 0;
        first  = -1;
        for (int i = 1; i <= 20; i++) begin
            tick(1);
            if (zxuno_regwr === 1'b1) begin
                pulses++;
                if (first < 0) first = i;
            end
        end
        chk("dw_pulses", pulses[15:0], 16'd1);
        chk("dw_latency", first[15:0], 16'd3);
        chk("dw_wdata", zxuno_wdata, 8'h5A);
        release_bus();
        tick(4);

        // Data port read, slave 2 answers 54
        slv_oe_n = 8'b1111_1011;
        slv_dout[23:16] = 8'h54;
        strobe(16'hFD3B, 8'h00, 1'b1, 1'b0);
        tick(2);
        chk("dr_early", zxuno_regrd, 1'b0);
        tick(1);
        chk("dr_regrd", zxuno_regrd, 1'b1);
        chk("dr_oe_n", cpu_oe_n, 1'b0);
        chk("dr_dout", cpu_dout, 8'h54);
        tick(5);
        chk("dr_regrd_held", zxuno_regrd, 1'b1);
        release_bus();
        tick(2);
        chk("dr_regrd_tail", zxuno_regrd, 1'b1);
        tick(1);
        chk("dr_regrd_fall", zxuno_regrd, 1'b0);
        chk("dr_oe_n_off", cpu_oe_n, 1'b1);
        chk("dr_no_conflict", conflict, 1'b0);
        tick(3);

        // Data port read, nobody answers, then slaves 1 and 3 collide
        slv_oe_n = 8'hFF;
        slv_dout = 64'h0;
        strobe(16'hFD3B, 8'h00, 1'b1, 1'b0);
        tick(3);
        chk("dr_none_dout", cpu_dout, 8'hFF);
        chk("dr_none_oe_n", cpu_oe_n, 1'b0);
        slv_oe_n = 8'b1111_0101;
        slv_dout[15:8]  = 8'h11;
        slv_dout[31:24] = 8'h33;
        tick(1);
        chk("dr_prio_dout", cpu_dout, 8'h11);
        chk("dr_conflict", conflict, 1'b1);
        release_bus();
        slv_oe_n = 8'hFF;
        tick(5);
        chk("conflict_sticky", conflict, 1'b1);

        // Address port write 0B, then read it back
        strobe(16'hFC3B, 8'h0B, 1'b0, 1'b1);
        tick(3);
        chk("aw0b_addr", zxuno_addr, 8'h0B);
        release_bus();
        tick(4);
        strobe(16'hFC3B, 8'h00, 1'b1, 1'b0);
        tick(3);
        chk("ar_dout", cpu_dout, 8'h0B);
        chk("ar_oe_n", cpu_oe_n, 1'b0);
        chk("ar_regrd", zxuno_regrd, 1'b0);
        release_bus();
        tick(4);
        chk("ar_oe_n_off", cpu_oe_n, 1'b1);

        // Rewriting the same register number still pulses
        strobe(16'hFC3B, 8'h0B, 1'b0, 1'b1);
        tick(3);
        chk("aw_same_pulse", regaddr_changed, 1'b1);
        release_bus();
        tick(4);

        // Reset mid-read with strobe held through release
        slv_oe_n = 8'b1111_1011;
        slv_dout[23:16] = 8'h54;
        strobe(16'hFD3B, 8'h00, 1'b1, 1'b0);
        tick(3);
        chk("rr_regrd_pre", zxuno_regrd, 1'b1);
        rst_n = 1'b0;
        tick(1);
        chk("rr_regrd_drop", zxuno_regrd, 1'b0);
        chk("rr_conflict_clr", conflict, 1'b0);
        tick(2);
        rst_n = 1'b1;
        tick(6);
        chk("rr_hold_regrd", zxuno_regrd, 1'b0);
        chk("rr_hold_oe_n", cpu_oe_n, 1'b1);
        release_bus();
        tick(4);
        strobe(16'hFD3B, 8'h00, 1'b1, 1'b0);
        tick(3);
        chk("rr_reaccess", zxuno_regrd, 1'b1);
        chk("rr_reaccess_dout", cpu_dout, 8'h54);
        release_bus();
        tick(4);

        // Read and write together: write wins
        strobe(16'hFD3B, 8'hC3, 1'b1, 1'b1);
        tick(3);
        chk("rw_regwr", zxuno_regwr, 1'b1);
        chk("rw_wdata", zxuno_wdata, 8'hC3);
        chk("rw_regrd", zxuno_regrd, 1'b0);
        release_bus();
        tick(4);

        // Unrelated port: no activity
        strobe(16'h00FE, 8'h77, 1'b0, 1'b1);
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            tick(1);
            if (zxuno_regwr === 1'b1 || regaddr_changed === 1'b1) pulses++;
        end
        chk("other_port_pulses", pulses[15:0], 16'd0);
        chk("other_port_addr", zxuno_addr, 8'h00);
        release_bus();
        tick(3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
